// File: rtl/bram_axis_reader_pkg.sv
// Shared types and sizing helpers for the BRAM-to-AXI-Stream reader.
package bram_axis_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    WAIT   = 2'd2,
    STREAM = 2'd3
  } state_t;

  function automatic int beats(input int bram_width, input int data_width);
    return bram_width / data_width;
  endfunction

  function automatic int beat_idx_width(input int n_beats);
    return (n_beats > 1) ? $clog2(n_beats) : 1;
  endfunction

  localparam int BEAT_IDX_W = beat_idx_width(beats(1152, 32));

endpackage

// File: rtl/bram_axis_reader_word_serializer.sv
// Holds one wide BRAM word and hands it out one DATA_WIDTH lane at a time, lane 0 first.
module word_serializer
  import bram_axis_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int BRAM_WIDTH = 1152,
  parameter int IDX_W      = beat_idx_width(beats(BRAM_WIDTH, DATA_WIDTH))
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [BRAM_WIDTH-1:0] load_word,
  input  logic                  advance,
  output logic [DATA_WIDTH-1:0] lane,
  output logic [IDX_W-1:0]      index,
  output logic                  last
);

  localparam int BEATS = beats(BRAM_WIDTH, DATA_WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

  logic [BRAM_WIDTH-1:0] shift_r;
  logic [IDX_W-1:0]      idx_r;

  // Word shift register and lane index; a load takes priority over an advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_r <= {BRAM_WIDTH{1'b0}};
      idx_r   <= {IDX_W{1'b0}};
    end else if (load) begin
      shift_r <= load_word;
      idx_r   <= {IDX_W{1'b0}};
    end else if (advance && (idx_r != LAST_IDX)) begin
      shift_r <= shift_r >> DATA_WIDTH;
      idx_r   <= idx_r + IDX_W'(1);
    end else begin
      shift_r <= shift_r;
      idx_r   <= idx_r;
    end
  end

  assign lane  = shift_r[DATA_WIDTH-1:0];
  assign index = idx_r;
  assign last  = (idx_r == LAST_IDX);

endmodule

// File: rtl/bram_axis_reader.sv
// Reads BRAM words start..bound (inclusive) and streams them as AXIS beats.
// Optional zero-bubble word prefetch: BRAM_AXIS_READER_PREFETCH_EN.
module bram_axis_reader
  import bram_axis_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int BRAM_WIDTH = 1152,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                    m00_axis_aclk,
  input  logic                    m00_axis_areset,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   bram_start_addr,
  input  logic [ADDR_WIDTH-1:0]   bram_bound_addr,
  output logic                    busy,
  output logic                    done,
  output logic                    BRAM_CLK,
  output logic                    BRAM_EN,
  output logic                    BRAM_WEN,
  output logic [ADDR_WIDTH-1:0]   BRAM_ADDR,
  input  logic [BRAM_WIDTH-1:0]   BRAM_OUT,
  output logic                    m00_axis_tvalid,
  output logic [DATA_WIDTH-1:0]   m00_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m00_axis_tstrb,
  output logic                    m00_axis_tlast,
  input  logic                    m00_axis_tready
);

  localparam int BEATS = beats(BRAM_WIDTH, DATA_WIDTH);
  localparam int IDX_W = beat_idx_width(BEATS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

  state_t                  state_r, state_n;
  logic [ADDR_WIDTH-1:0]   cur_addr_r, cur_addr_n;
  logic [ADDR_WIDTH-1:0]   bound_r, bound_n;
  logic [ADDR_WIDTH-1:0]   bram_addr_r, bram_addr_n;
  logic                    bram_en_r, bram_en_n;
  logic                    busy_r, busy_n;
  logic                    done_r, done_n;
  logic                    tvalid_r;
  logic                    arrive_r;
  logic                    load_s;
  logic [BRAM_WIDTH-1:0]   load_word_s;
  logic                    handshake_s;
  logic                    last_lane_s;
  logic [DATA_WIDTH-1:0]   lane_s;
  logic [IDX_W-1:0]        index_s;

`ifdef BRAM_AXIS_READER_PREFETCH_EN
  logic [BRAM_WIDTH-1:0]   hold_r;
  logic                    hold_valid_r;
  logic [ADDR_WIDTH-1:0]   fetch_addr_r, fetch_addr_n;
  logic                    hold_load_s;
  logic                    hold_clr_s;
  logic                    issue_s;

  // A prefetch read goes out only when the holding register is empty and nothing is in flight.
  assign issue_s = ((state_r == WAIT) || (state_r == STREAM)) && (fetch_addr_r != bound_r) &&
                   !hold_valid_r && !bram_en_r && !arrive_r;
`endif

  assign handshake_s = tvalid_r & m00_axis_tready;

  word_serializer #(
    .DATA_WIDTH (DATA_WIDTH),
    .BRAM_WIDTH (BRAM_WIDTH),
    .IDX_W      (IDX_W)
  ) u_ser (
    .clk       (m00_axis_aclk),
    .rst       (m00_axis_areset),
    .load      (load_s),
    .load_word (load_word_s),
    .advance   (handshake_s),
    .lane      (lane_s),
    .index     (index_s),
    .last      (last_lane_s)
  );

  // Next-state, address and serializer-load decisions.
  always_comb begin
    state_n     = state_r;
    cur_addr_n  = cur_addr_r;
    bound_n     = bound_r;
    busy_n      = busy_r;
    done_n      = 1'b0;
    bram_en_n   = 1'b0;
    bram_addr_n = bram_addr_r;
    load_s      = 1'b0;
    load_word_s = BRAM_OUT;
`ifdef BRAM_AXIS_READER_PREFETCH_EN
    fetch_addr_n = fetch_addr_r;
    hold_clr_s   = 1'b0;
    hold_load_s  = (state_r == STREAM) && arrive_r;
`endif
    case (state_r)
      IDLE: begin
        if (start) begin
          if (bram_bound_addr < bram_start_addr) begin
            done_n = 1'b1;
          end else begin
            state_n     = FETCH;
            cur_addr_n  = bram_start_addr;
            bound_n     = bram_bound_addr;
            busy_n      = 1'b1;
            bram_en_n   = 1'b1;
            bram_addr_n = bram_start_addr;
`ifdef BRAM_AXIS_READER_PREFETCH_EN
            fetch_addr_n = bram_start_addr;
`endif
          end
        end else begin
          state_n = IDLE;
        end
      end
      FETCH: state_n = WAIT;
      WAIT: begin
        if (arrive_r) begin
          load_s  = 1'b1;
          state_n = STREAM;
        end else begin
          state_n = WAIT;
        end
      end
      STREAM: begin
        if (handshake_s && last_lane_s) begin
          if (cur_addr_r == bound_r) begin
            state_n = IDLE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end else begin
            cur_addr_n = cur_addr_r + ADDR_WIDTH'(1);
`ifdef BRAM_AXIS_READER_PREFETCH_EN
            if (hold_valid_r) begin
              load_s      = 1'b1;
              load_word_s = hold_r;
              hold_clr_s  = 1'b1;
            end else if (arrive_r) begin
              // Word lands exactly at the switch: bypass the holding register.
              load_s      = 1'b1;
              hold_load_s = 1'b0;
            end else begin
              state_n = WAIT;
            end
`else
            state_n     = FETCH;
            bram_en_n   = 1'b1;
            bram_addr_n = cur_addr_r + ADDR_WIDTH'(1);
`endif
          end
        end else begin
          state_n = STREAM;
        end
      end
      default: state_n = IDLE;
    endcase
`ifdef BRAM_AXIS_READER_PREFETCH_EN
    bram_en_n    = bram_en_n | issue_s;
    bram_addr_n  = issue_s ? (fetch_addr_r + ADDR_WIDTH'(1)) : bram_addr_n;
    fetch_addr_n = issue_s ? (fetch_addr_r + ADDR_WIDTH'(1)) : fetch_addr_n;
`endif
  end

  // Control, address and output registers.
  always_ff @(posedge m00_axis_aclk) begin
    if (m00_axis_areset) begin
      state_r     <= IDLE;
      cur_addr_r  <= {ADDR_WIDTH{1'b0}};
      bound_r     <= {ADDR_WIDTH{1'b0}};
      bram_addr_r <= {ADDR_WIDTH{1'b0}};
      bram_en_r   <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      tvalid_r    <= 1'b0;
      arrive_r    <= 1'b0;
    end else begin
      state_r     <= state_n;
      cur_addr_r  <= cur_addr_n;
      bound_r     <= bound_n;
      bram_addr_r <= bram_addr_n;
      bram_en_r   <= bram_en_n;
      busy_r      <= busy_n;
      done_r      <= done_n;
      tvalid_r    <= (state_n == STREAM);
      arrive_r    <= bram_en_r;
    end
  end

`ifdef BRAM_AXIS_READER_PREFETCH_EN
  // Holding register for the prefetched next word.
  always_ff @(posedge m00_axis_aclk) begin
    if (m00_axis_areset) begin
      hold_r       <= {BRAM_WIDTH{1'b0}};
      hold_valid_r <= 1'b0;
      fetch_addr_r <= {ADDR_WIDTH{1'b0}};
    end else begin
      fetch_addr_r <= fetch_addr_n;
      if (hold_load_s) begin
        hold_r       <= BRAM_OUT;
        hold_valid_r <= 1'b1;
      end else if (hold_clr_s) begin
        hold_r       <= hold_r;
        hold_valid_r <= 1'b0;
      end else begin
        hold_r       <= hold_r;
        hold_valid_r <= hold_valid_r;
      end
    end
  end
`endif

  assign busy            = busy_r;
  assign done            = done_r;
  assign BRAM_CLK        = m00_axis_aclk;
  assign BRAM_EN         = bram_en_r;
  assign BRAM_WEN        = 1'b0;
  assign BRAM_ADDR       = bram_addr_r;
  assign m00_axis_tvalid = tvalid_r;
  assign m00_axis_tdata  = lane_s;
  assign m00_axis_tstrb  = {(DATA_WIDTH/8){1'b1}};
  assign m00_axis_tlast  = tvalid_r && (cur_addr_r == bound_r) && (index_s == LAST_IDX);

endmodule

// File: doc/bram_axis_reader.md
# bram_axis_reader

Read-side counterpart of the AXIS-to-BRAM write adapter. On a start pulse it reads a contiguous range of wide BRAM words (start through bound, inclusive) and serializes each word into 32-bit AXI-Stream beats on a master port, lane 0 first. It asserts tlast on the final beat of the final word. It sits between the wide BRAM and the downstream AXIS consumer (DMA S2MM).

## Interface
Parameters:
- DATA_WIDTH, 32, AXIS beat width
- BRAM_WIDTH, 1152, BRAM word width; must be a multiple of DATA_WIDTH
- ADDR_WIDTH, 12, BRAM word-address width

Ports:
- m00_axis_aclk  in  1  single clock for the whole block; BRAM and AXIS share it
- m00_axis_areset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; latches the address range; ignored while busy
- bram_start_addr  in  ADDR_WIDTH  first word address
- bram_bound_addr  in  ADDR_WIDTH  last word address, inclusive
- busy  out  1  high from the accepted start until done
- done  out  1  one-cycle pulse after the last handshake, or after an empty range
- BRAM_CLK  out  1  equal to m00_axis_aclk
- BRAM_EN  out  1  read enable
- BRAM_WEN  out  1  tied 0
- BRAM_ADDR  out  ADDR_WIDTH  read address
- BRAM_OUT  in  BRAM_WIDTH  BRAM read data; valid 1 cycle after an EN cycle
- m00_axis_tvalid  out  1
- m00_axis_tdata  out  DATA_WIDTH
- m00_axis_tstrb  out  DATA_WIDTH/8  all ones
- m00_axis_tlast  out  1
- m00_axis_tready  in  1

## Operation
- BEATS = BRAM_WIDTH/DATA_WIDTH (36). Beat i of a word = BRAM_OUT[i*DATA_WIDTH +: DATA_WIDTH].
- FSM states: IDLE, FETCH, WAIT, STREAM.
- IDLE + start:
  - if bound < start: pulse done next cycle; no BRAM access, no beats.
  - otherwise latch the current address (cur_addr) and the bound, then go to FETCH.
- FETCH: BRAM_EN=1, BRAM_ADDR=cur_addr; go to WAIT.
- WAIT: capture BRAM_OUT into the shift register, set beat index to 0, go to STREAM.
- STREAM:
  - tvalid=1 and tdata = current lane.
  - On handshake (tvalid & tready), advance the lane.
  - On the handshake of beat BEATS-1:
    - if cur_addr == bound: go to IDLE and pulse done;
    - else increment cur_addr and refill (see Configuration).
- tlast = (cur_addr == bound) && (index == BEATS-1).
- AXIS rules:
  - tvalid never depends on tready.
  - tdata and tlast are held stable while tvalid & !tready.
  - No beat is dropped or duplicated.
- Address arithmetic is ADDR_WIDTH-wide. The inclusive range up to the maximum address terminates by comparison, not by wrap.
- A start pulse while busy is ignored; the latched range is unchanged.
- Reset values: tvalid, tlast, BRAM_EN, busy and done are 0; tdata and BRAM_ADDR are 0; state is IDLE.
- Reset mid-operation:
  - everything returns to reset values the next cycle;
  - no done pulse is issued;
  - any partial stream is abandoned.

## Timing
- Start sampled at edge k:
  - BRAM_EN high in cycle k+1;
  - data captured at edge k+2;
  - tvalid high from edge k+2 (first-beat latency 2 cycles).
- Sustained throughput with tready=1 is 1 beat per cycle within a word.
- Inter-word gap depends on configuration (below).
- done rises 1 cycle after the final handshake edge. busy falls at the same edge.

## Configuration
- BRAM_AXIS_READER_PREFETCH_EN defined:
  - a second BRAM_WIDTH holding register is added;
  - the next word's read is issued as soon as the holding register is empty and a next word exists;
  - on the last-beat handshake the shift register loads from the holding register;
  - result: zero bubble between words and a continuous 1 beat/cycle stream.
- Undefined:
  - after the last-beat handshake go FETCH → WAIT → STREAM;
  - result: exactly 2 cycles with tvalid=0 between words;
  - no holding register.

## Structure
- Package bram_axis_pkg holds:
  - the state enum (IDLE/FETCH/WAIT/STREAM);
  - the function BEATS = BRAM_WIDTH/DATA_WIDTH;
  - the beat-index width constant ($clog2(BEATS)).
- One sub-module, word_serializer:
  - loads a BRAM_WIDTH word;
  - presents the current lane and index;
  - advances on a handshake;
  - flags the last lane.
- The FSM, address counter and prefetch logic stay in the top module.

## Test plan
1. BRAM model word a holds lanes a*36+i. Start with start=3, bound=7, tready=1, macro defined → 180 beats with values 108..287 in order, no gaps; tlast only on beat 180; done 1 cycle later.
2. Same stimulus, macro undefined → identical data; exactly 2 idle cycles between each pair of words; 188 cycles from the first tvalid to the last handshake.
3. tready toggles 1/0 every cycle; a second start pulse is issued mid-stream → tdata/tlast stable during stalls; exactly 180 beats; second start ignored.
4. start=5, bound=5 → 36 beats with values 180..215; tlast on the 36th; one BRAM_EN cycle.
5. start=7, bound=3 → BRAM_EN never high; tvalid never high; done pulse 1 cycle after start.
6. Reset asserted at beat 50 of test 1 → tvalid=0 next cycle and no done. Then start=0, bound=0 → 36 beats with values 0..35.
